// File: rtl/sram_bist_ctrl_if.sv
// SRAM port bundle between the BIST controller (master) and a cascaded-SRAM instance (slave).
interface sram_bist_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [DATA_W-1:0] sram_din;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic              sram_cs;
    logic [DATA_W-1:0] sram_dout;

    modport master (
        output sram_din,
        output sram_addr,
        output sram_we,
        output sram_cs,
        input  sram_dout
    );

    modport slave (
        input  sram_din,
        input  sram_addr,
        input  sram_we,
        input  sram_cs,
        output sram_dout
    );
endinterface

// File: rtl/sram_bist_ctrl.sv
// Four-pass SRAM BIST: write pattern, read-compare, write inverse, read-compare.
// Reports pass/fail, a saturating error count and the first failing address.
module sram_bist_ctrl #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 3,
    parameter logic [DATA_W-1:0]    SEED     = 8'hA5,
    parameter logic [DATA_W-1:0]    PAT_STEP = 8'h3B
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   err_count,
    output logic [ADDR_W-1:0]   fail_addr,
    sram_bist_ctrl_if.master    sram
);

    typedef enum logic [2:0] {StIdle, StWr0, StRd0, StWr1, StRd1, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [ADDR_W+1:0] ErrOne  = (ADDR_W+2)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W+1:0]   err_q;
    logic [ADDR_W-1:0]   fail_q;
    logic                done_q, pass_q;
    logic [DATA_W-1:0]   pat, expect_val;
    logic                addr_last, launch, cmp_en, mismatch;

    assign pat        = SEED + DATA_W'(addr_q) * PAT_STEP;
    assign addr_last  = &addr_q;
    assign launch     = ((state_q == StIdle) || (state_q == StDone)) && start;
    assign cmp_en     = (state_q == StRd0) || (state_q == StRd1);
    assign expect_val = (state_q == StRd1) ? ~pat : pat;
    assign mismatch   = cmp_en && (sram.sram_dout != expect_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StWr0;
            StWr0:          if (addr_last) state_d = StRd0;
            StRd0:          if (addr_last) state_d = StWr1;
            StWr1:          if (addr_last) state_d = StRd1;
            StRd1:          if (addr_last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
        // Address wraps to 0 on every state change and rests at 0 outside the test.
        if ((state_d != state_q) || (state_d == StIdle) || (state_d == StDone)) begin
            addr_d = '0;
        end else begin
            addr_d = addr_q + AddrOne;
        end
    end

    always_comb begin
        busy           = 1'b0;
        sram.sram_cs   = 1'b0;
        sram.sram_we   = 1'b0;
        sram.sram_din  = '0;
        sram.sram_addr = addr_q;
        unique case (state_q)
            StWr0: begin
                busy = 1'b1; sram.sram_cs = 1'b1; sram.sram_we = 1'b1; sram.sram_din = pat;
            end
            StWr1: begin
                busy = 1'b1; sram.sram_cs = 1'b1; sram.sram_we = 1'b1; sram.sram_din = ~pat;
            end
            StRd0, StRd1: begin
                busy = 1'b1; sram.sram_cs = 1'b1;
            end
            default: ;
        endcase
    end

    // Result registers; done/pass settle one edge after DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= '0;
            fail_q <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (launch) begin
            err_q  <= '0;
            fail_q <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            if (state_q == StDone) begin
                done_q <= 1'b1;
                pass_q <= (err_q == '0);
            end
            if (mismatch) begin
                if (err_q == '0) fail_q <= addr_q;
                if (err_q != '1) err_q <= err_q + ErrOne;
            end
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: behavioural SRAM with per-address read masks as fault injection.
module tb_sram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [2:0] fail_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    logic [7:0] mem   [8];
    logic [7:0] fmask [8];

    typedef struct {
        logic       pass;
        logic [4:0] err;
        logic [2:0] fail;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sram_bist_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    sram_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .sram      (bus.master)
    );

    always @(posedge clk) begin
        if (bus.sram_cs && bus.sram_we) begin
            mem[bus.sram_addr] <= bus.sram_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign bus.sram_dout = mem[bus.sram_addr] & fmask[bus.sram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_of(input int a);
        logic [7:0] p;
        p = 8'hA5;
        for (int i = 0; i < a; i++) p = p + 8'h3B;
        return p;
    endfunction

    function automatic exp_t model();
        exp_t       e;
        logic [7:0] wv;
        int         errs;
        e.fail = '0;
        errs   = 0;
        for (int ps = 0; ps < 2; ps++) begin
            for (int a = 0; a < 8; a++) begin
                wv = (ps == 0) ? pat_of(a) : ~pat_of(a);
                if ((wv & fmask[a]) != wv) begin
                    if (errs == 0) e.fail = 3'(a);
                    errs++;
                end
            end
        end
        e.err  = (errs > 31) ? 5'd31 : 5'(errs);
        e.pass = (errs == 0);
        return e;
    endfunction

    task automatic run(input bit bus_chk, input bit restart);
        exp_t e;
        int   n, busy_n;
        bit   seen;
        sb.push_back(model());
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; busy_n = 0; seen = 0;
        while (n < 100) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                break;
            end
            if (bus_chk) begin
                case (n)
                    0: begin
                        check("wr0_addr", 32'(bus.sram_addr), 32'd0);
                        check("wr0_we",   32'(bus.sram_we), 32'd1);
                        check("wr0_cs",   32'(bus.sram_cs), 32'd1);
                        check("wr0_din0", 32'(bus.sram_din), 32'hA5);
                    end
                    1:  check("wr0_din1", 32'(bus.sram_din), 32'hE0);
                    8:  check("rd0_wecs", {bus.sram_we, bus.sram_cs}, 32'b01);
                    16: check("wr1_din0", 32'(bus.sram_din), 32'h5A);
                    24: check("rd1_wecs", {bus.sram_we, bus.sram_cs}, 32'b01);
                    default: ;
                endcase
            end
            if (restart && n == 10) start = 1'b1;
            if (restart && n == 11) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        check("latency",   32'(n), 32'd33);
        check("busy_cyc",  32'(busy_n), 32'd32);
        check("pass",      32'(pass), 32'(e.pass));
        check("err_count", 32'(err_count), 32'(e.err));
        check("fail_addr", 32'(fail_addr), 32'(e.fail));
        @(posedge clk);
        #1;
        check("done_hold", {done, busy, bus.sram_cs}, 32'b100);
    endtask

    task automatic abort_mid_wr1();
        int w;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (18) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy_done", {busy, done, pass}, 32'd0);
        check("rst_bus", {bus.sram_cs, bus.sram_we, bus.sram_addr, bus.sram_din}, 32'd0);
        check("rst_cnt", {err_count, fail_addr}, 32'd0);
        w = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_writes", 32'(wr_cnt), 32'(w));
        check("rst_cs_held", 32'(bus.sram_cs), 32'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) fmask[i] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_status", {busy, done, pass, err_count, fail_addr}, 32'd0);
        check("reset_bus", {bus.sram_cs, bus.sram_we, bus.sram_addr, bus.sram_din}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("idle_status", {busy, done, bus.sram_cs}, 32'd0);

        run(1'b1, 1'b0);

        fmask[5] = 8'hFE;
        run(1'b0, 1'b0);

        fmask[5] = 8'hFF;
        fmask[2] = 8'h00;
        fmask[6] = 8'h00;
        run(1'b0, 1'b0);

        fmask[2] = 8'hFF;
        fmask[6] = 8'hFF;
        run(1'b0, 1'b1);
        run(1'b0, 1'b0);

        abort_mid_wr1();
        run(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Sequential initiator that drives the SRAM port (data in, address, write enable, chip select; combinational read data out).
- Runs a four-pass write/read-compare test over every address and reports pass/fail, error count and first failing address.
- Sits between a test/boot sequencer and any SRAM instance with the cascaded-SRAM interface, and replaces hand-written write-all/read-all stimulus.

Parameters:
- DATA_W, 8, SRAM word width
- ADDR_W, 3, SRAM address width; DEPTH = 2**ADDR_W
- SEED, 8'hA5, base data pattern (DATA_W bits)
- PAT_STEP, 8'h3B, per-address pattern increment (DATA_W bits)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin test; sampled only in IDLE or DONE
- busy  out  1  test in progress
- done  out  1  test finished; held until next start or reset
- pass  out  1  valid when done=1; 1 = zero mismatches
- err_count  out  ADDR_W+2  saturating mismatch count
- fail_addr  out  ADDR_W  address of first mismatch; valid when done=1 and pass=0
- sram_din  out  DATA_W  write data to SRAM
- sram_addr  out  ADDR_W  SRAM address
- sram_we  out  1  1 = write, 0 = read
- sram_cs  out  1  SRAM chip select
- sram_dout  in  DATA_W  SRAM read data, combinational from sram_addr

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including sram_cs, sram_we, sram_addr, sram_din, busy, done, pass, err_count, fail_addr.
- Pattern: pat(a) = (SEED + a*PAT_STEP) mod 2**DATA_W.
- States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE.
  - Each test state lasts exactly DEPTH cycles, with the address counter running 0..DEPTH-1 one step per cycle.
  - The counter wraps to 0 on each state change.
- IDLE/DONE: start=1 at a rising edge -> WR0 with addr 0 next cycle. Entering WR0 clears err_count, fail_addr, pass and done.
- WR0: sram_cs=1, sram_we=1, sram_din=pat(addr).
- RD0: sram_cs=1, sram_we=0, sram_din=0. Compare sram_dout against pat(addr) at the rising edge that ends the cycle.
- WR1: as WR0 with sram_din=~pat(addr).
- RD1: as RD0, comparing against ~pat(addr).
- Mismatch handling:
  - err_count increments by 1 and saturates at all-ones.
  - fail_addr is captured only on the first mismatch of the run.
- busy=1 in WR0/RD0/WR1/RD1, 0 otherwise. sram_cs=0 and sram_we=0 in IDLE and DONE.
- DONE: done=1; pass=1 iff err_count==0.
- Latency: done rises 4*DEPTH+1 rising edges after the edge that sampled start (33 for defaults).
- start while busy=1 is ignored, with no restart and no effect on counters.
- Reset mid-run aborts immediately, with no further SRAM writes; the next start runs a full test from WR0 addr 0.
- Registered outputs only; no combinational path from start to any output.

Test Plan:
- Fault-free behavioural SRAM (DEPTH 8), start pulsed 1 cycle -> busy high 32 cycles; done=1 at edge 33; pass=1; err_count=0; fail_addr=0.
- Bus sequence check:
  - First WR0 cycle shows sram_addr=0, sram_we=1, sram_cs=1, sram_din=8'hA5.
  - Addr 1 shows din=8'hE0.
  - First WR1 cycle shows din=8'h5A.
  - RD cycles show we=0, cs=1.
- Stuck-at-0 on bit 0 of address 5 -> pat(5)=8'hCC passes RD0; ~pat=8'h33 fails RD1 -> done=1, pass=0, err_count=1, fail_addr=5.
- Whole-word stuck at 8'h00 on address 2 plus address 6 -> both fail in RD0 and RD1 -> err_count=4, fail_addr=2.
- start re-pulsed during RD0 -> ignored; done still at edge 33 of the original run; second start after DONE clears counters and reruns in 32 cycles.
- rst asserted asynchronously mid-WR1 -> outputs 0 without waiting for a clock edge, sram_cs=0 and no further writes; after release, start gives a clean full run with pass=1.
